// File: rtl/mc_core_pkg.sv
// Shared types for the multicycle core: FSM state encoding, opcode map and field widths.
package cpu_package;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned OP_WIDTH   = 3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDec,
    StExec,
    StWb,
    StHalt
  } Type_pipeline_state;

  typedef enum logic [OP_WIDTH-1:0] {
    OpNop  = 3'd0,
    OpLdi  = 3'd1,
    OpMov  = 3'd2,
    OpAdd  = 3'd3,
    OpSub  = 3'd4,
    OpAnd  = 3'd5,
    OpBnz  = 3'd6,
    OpHalt = 3'd7
  } Type_opcode;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational operand reads, one debug read, one synchronous write.
module mc_regfile #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned WORD_WIDTH = 16,
  localparam int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr_a,
  input  logic [AW-1:0]         raddr_b,
  output logic [WORD_WIDTH-1:0] rdata_a,
  output logic [WORD_WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]         dbg_sel,
  output logic [WORD_WIDTH-1:0] dbg_rdata
);

  logic [WORD_WIDTH-1:0] rf [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata_a   = rf[raddr_a];
  assign rdata_b   = rf[raddr_b];
  assign dbg_rdata = rf[dbg_sel];

endmodule

// File: rtl/mc_core.sv
// Multicycle CPU core: loadable instruction memory, 4-cycle FETCH/DEC/EXEC/WB loop,
// conditional branch, halt/restart control and debug register visibility.
module mc_core #(
  parameter int unsigned WORD_WIDTH = cpu_package::WORD_WIDTH,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned REG_AW    = $clog2(NUM_REGS),
  localparam int unsigned PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_we,
  input  logic [PC_W-1:0]       imem_waddr,
  input  logic [WORD_WIDTH-1:0] imem_wdata,
  input  logic                  start,
  input  logic [REG_AW-1:0]     dbg_sel,
  output logic [WORD_WIDTH-1:0] dbg_rdata,
  output logic                  busy,
  output logic                  halted,
  output logic [PC_W-1:0]       pc,
  output logic [CNT_WIDTH-1:0]  retired
);
  import cpu_package::*;

  localparam int IMM_W = int'(WORD_WIDTH) - int'(OP_WIDTH) - 2 * int'(REG_AW);

  if (IMM_W < int'(PC_W)) begin : g_bad_params
    $error("mc_core: immediate field narrower than program counter");
  end

  Type_pipeline_state state_q, state_d;

  logic [WORD_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [WORD_WIDTH-1:0] ir_q;
  logic [PC_W-1:0]       pc_q;
  logic [CNT_WIDTH-1:0]  retired_q;
  Type_opcode            op_q;
  logic [WORD_WIDTH-1:0] a_q, b_q, result_q, alu;
  logic                  take_q, take;

  logic [OP_WIDTH-1:0] ir_op;
  logic [REG_AW-1:0]   ir_rd, ir_rs;
  logic [IMM_W-1:0]    ir_imm;
  logic                idle_like, rf_we;
  logic [WORD_WIDTH-1:0] rdata_a, rdata_b;

  assign ir_op  = ir_q[WORD_WIDTH-1 -: OP_WIDTH];
  assign ir_rd  = ir_q[WORD_WIDTH-OP_WIDTH-1 -: REG_AW];
  assign ir_rs  = ir_q[WORD_WIDTH-OP_WIDTH-REG_AW-1 -: REG_AW];
  assign ir_imm = ir_q[IMM_W-1:0];

  assign idle_like = (state_q == StIdle) || (state_q == StHalt);

  // Program memory is writable only while the core is not executing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
    end else if (imem_we && idle_like) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StDec;
      StDec:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = (op_q == OpHalt) ? StHalt : StFetch;
      StHalt:  if (start) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op_q)
      OpLdi:   alu = WORD_WIDTH'(ir_imm);
      OpMov:   alu = b_q;
      OpAdd:   alu = a_q + b_q;
      OpSub:   alu = a_q - b_q;
      OpAnd:   alu = a_q & b_q;
      default: alu = '0;
    endcase
  end

  assign take = (op_q == OpBnz) && (a_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      retired_q <= '0;
      ir_q      <= '0;
      op_q      <= OpNop;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      take_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            pc_q      <= '0;
            retired_q <= '0;
          end
        end
        StFetch: ir_q <= imem[pc_q];
        StDec: begin
          op_q <= Type_opcode'(ir_op);
          a_q  <= rdata_a;
          b_q  <= rdata_b;
        end
        StExec: begin
          result_q <= alu;
          take_q   <= take;
        end
        StWb: begin
          // HALT keeps pc on the halt instruction; sequential pc wraps at IMEM_DEPTH.
          if (take_q)                pc_q <= ir_imm[PC_W-1:0];
          else if (op_q != OpHalt)   pc_q <= pc_q + PC_W'(1);
          if (retired_q != '1)       retired_q <= retired_q + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign rf_we = (state_q == StWb) &&
                 (op_q == OpLdi || op_q == OpMov || op_q == OpAdd ||
                  op_q == OpSub || op_q == OpAnd);

  mc_regfile #(
    .NUM_REGS   (NUM_REGS),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (rf_we),
    .waddr     (ir_rd),
    .wdata     (result_q),
    .raddr_a   (ir_rd),
    .raddr_b   (ir_rs),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .dbg_sel   (dbg_sel),
    .dbg_rdata (dbg_rdata)
  );

  assign busy    = (state_q == StFetch) || (state_q == StDec) ||
                   (state_q == StExec)  || (state_q == StWb);
  assign halted  = (state_q == StHalt);
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: table of small programs plus hand sequences for wrap, lockout and reset.
module tb_mc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        start;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_rdata;
  logic        busy, halted;
  logic [4:0]  pc;
  logic [15:0] retired;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mc_core #(
    .WORD_WIDTH (16),
    .NUM_REGS   (8),
    .IMEM_DEPTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .start      (start),
    .dbg_sel    (dbg_sel),
    .dbg_rdata  (dbg_rdata),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .retired    (retired)
  );

  localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, AND = 3'd5, BNZ = 3'd6, HLT = 3'd7;

  typedef struct {
    logic [7:0][15:0] prog;
    int unsigned      len;
    logic [2:0]       chk_reg;
    logic [15:0]      chk_val;
    logic [15:0]      exp_ret;
    logic [4:0]       exp_pc;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [6:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [2:0] r, input logic [15:0] exp);
    dbg_sel = r;
    #1;
    check(name, {16'h0, dbg_rdata}, {16'h0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_word(input logic [4:0] a, input logic [15:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    @(negedge clk);
    imem_we    = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int unsigned w = 0; w < v.len; w++) write_word(5'(w), v.prog[w]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned budget, output int unsigned cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  int unsigned cyc;

  initial begin
    reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    start = 1'b0; dbg_sel = '0;

    vecs[0].prog = '0; vecs[0].len = 4;
    vecs[0].prog[0] = enc(LDI, 1, 0, 5);
    vecs[0].prog[1] = enc(LDI, 2, 0, 3);
    vecs[0].prog[2] = enc(ADD, 1, 2, 0);
    vecs[0].prog[3] = enc(HLT, 0, 0, 0);
    vecs[0].chk_reg = 1; vecs[0].chk_val = 16'd8; vecs[0].exp_ret = 4; vecs[0].exp_pc = 3;

    vecs[1].prog = '0; vecs[1].len = 4;
    vecs[1].prog[0] = enc(LDI, 1, 0, 0);
    vecs[1].prog[1] = enc(LDI, 2, 0, 1);
    vecs[1].prog[2] = enc(SUB, 1, 2, 0);
    vecs[1].prog[3] = enc(HLT, 0, 0, 0);
    vecs[1].chk_reg = 1; vecs[1].chk_val = 16'hFFFF; vecs[1].exp_ret = 4; vecs[1].exp_pc = 3;

    vecs[2].prog = '0; vecs[2].len = 5;
    vecs[2].prog[0] = enc(LDI, 1, 0, 3);
    vecs[2].prog[1] = enc(LDI, 2, 0, 1);
    vecs[2].prog[2] = enc(SUB, 1, 2, 0);
    vecs[2].prog[3] = enc(BNZ, 1, 0, 2);
    vecs[2].prog[4] = enc(HLT, 0, 0, 0);
    vecs[2].chk_reg = 1; vecs[2].chk_val = 16'd0; vecs[2].exp_ret = 9; vecs[2].exp_pc = 4;

    vecs[3].prog = '0; vecs[3].len = 5;
    vecs[3].prog[0] = enc(LDI, 1, 0, 7'd108);
    vecs[3].prog[1] = enc(LDI, 2, 0, 7'd58);
    vecs[3].prog[2] = enc(AND, 1, 2, 0);
    vecs[3].prog[3] = enc(MOV, 3, 1, 0);
    vecs[3].prog[4] = enc(HLT, 0, 0, 0);
    vecs[3].chk_reg = 3; vecs[3].chk_val = 16'h0028; vecs[3].exp_ret = 5; vecs[3].exp_pc = 4;

    do_reset();
    check("reset_busy",    {31'h0, busy},   32'd0);
    check("reset_halted",  {31'h0, halted}, 32'd0);
    check("reset_pc",      {27'h0, pc},     32'd0);
    check("reset_retired", {16'h0, retired}, 32'd0);
    check_reg("reset_r1", 3'd1, 16'h0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      load(vecs[i]);
      pulse_start();
      wait_halt(400, cyc);
      check($sformatf("v%0d_halted", i), {31'h0, halted}, 32'd1);
      check($sformatf("v%0d_cycles", i), cyc, 4 * 32'(vecs[i].exp_ret));
      check($sformatf("v%0d_busy", i), {31'h0, busy}, 32'd0);
      check($sformatf("v%0d_retired", i), {16'h0, retired}, {16'h0, vecs[i].exp_ret});
      check($sformatf("v%0d_pc", i), {27'h0, pc}, {27'h0, vecs[i].exp_pc});
      check_reg($sformatf("v%0d_reg", i), vecs[i].chk_reg, vecs[i].chk_val);
    end

    // All-NOP memory: pc walks 0..31 then wraps to 0 without halting.
    do_reset();
    pulse_start();
    for (int unsigned k = 0; k <= 32; k++) begin
      check($sformatf("nop_pc_%0d", k), {27'h0, pc}, k % 32);
      check($sformatf("nop_ret_%0d", k), {16'h0, retired}, k);
      repeat (4) @(negedge clk);
    end
    check("nop_retired33", {16'h0, retired}, 32'd33);
    check("nop_busy",      {31'h0, busy},   32'd1);
    check("nop_nohalt",    {31'h0, halted}, 32'd0);

    // start and imem_we while busy must be ignored.
    do_reset();
    load(vecs[0]);
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1; imem_we = 1'b1; imem_waddr = 5'd3; imem_wdata = enc(LDI, 1, 0, 99);
    @(negedge clk);
    start = 1'b0; imem_we = 1'b0;
    wait_halt(200, cyc);
    check("busy_ign_halted",  {31'h0, halted}, 32'd1);
    check("busy_ign_retired", {16'h0, retired}, 32'd4);
    check("busy_ign_pc",      {27'h0, pc}, 32'd3);
    check_reg("busy_ign_r1", 3'd1, 16'd8);

    // Reload while halted; word 0 written in the same cycle as start.
    write_word(5'd1, enc(HLT, 0, 0, 0));
    imem_we = 1'b1; imem_waddr = 5'd0; imem_wdata = enc(LDI, 4, 0, 7);
    start = 1'b1;
    @(negedge clk);
    imem_we = 1'b0; start = 1'b0;
    check("restart_pc",      {27'h0, pc}, 32'd0);
    check("restart_retired", {16'h0, retired}, 32'd0);
    check("restart_busy",    {31'h0, busy}, 32'd1);
    wait_halt(200, cyc);
    check("restart_cycles",  cyc, 32'd8);
    check("restart_ret2",    {16'h0, retired}, 32'd2);
    check("restart_pc1",     {27'h0, pc}, 32'd1);
    check_reg("restart_r4", 3'd4, 16'd7);
    check_reg("restart_r1_kept", 3'd1, 16'd8);

    // Asynchronous reset during EXEC of the ADD (third instruction).
    do_reset();
    load(vecs[0]);
    pulse_start();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy",    {31'h0, busy}, 32'd0);
    check("rst_pc",      {27'h0, pc}, 32'd0);
    check("rst_retired", {16'h0, retired}, 32'd0);
    check_reg("rst_r1", 3'd1, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_stay_busy",   {31'h0, busy}, 32'd0);
    check("rst_stay_halted", {31'h0, halted}, 32'd0);
    check_reg("rst_r2", 3'd2, 16'd0);
    pulse_start();
    repeat (8) @(negedge clk);
    check("rst_imem_ret",  {16'h0, retired}, 32'd2);
    check("rst_imem_busy", {31'h0, busy}, 32'd1);
    check_reg("rst_imem_r1", 3'd1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
